mdu_controller: RTL

Iterative multiply/divide controller for the RV32M extension, attached to the EX stage beside the integer ALU. It accepts one M-type operation at a time, runs a shift-add multiply or a restoring divide over 32 cycles, and stalls the pipeline until the result is ready. It also handles division by zero and signed overflow in one cycle, and holds its result while the pipeline is frozen by memory.

---
 rtl/mdu_pkg.sv | 29 ++
 rtl/mdu_iter_core.sv | 38 +++
 rtl/mdu_controller.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the RV32M multiply/divide controller.
//   - FUNC3 operation encodings
//   - controller state enum (IDLE/CALC/DONE)
//   - default datapath width and iteration-counter width helper
package mdu_pkg;

    localparam int unsigned MDU_XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    // Counter width able to index XLEN iterations (0..XLEN-1).
    function automatic int unsigned mdu_cnt_w(input int unsigned xlen);
        return $clog2(xlen);
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: one combinational iteration of the multiply/divide datapath.
//   acc      in  2*XLEN  current accumulator {hi, lo}
//   operand  in  XLEN    multiplicand (multiply) or divisor (divide) magnitude
//   div_mode in  1       0: shift-add multiply step, 1: restoring divide step
//   acc_nxt  out 2*XLEN  accumulator after this step
module mdu_iter_core
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN = MDU_XLEN
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    input  logic              div_mode,
    output logic [2*XLEN-1:0] acc_nxt
);

    logic [XLEN:0] add_sum;
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    always_comb begin
        // Multiply: lo holds the multiplier; add into hi on its lsb, then shift right.
        add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        // Divide: {rem, quo} shifts left by one; keep the subtraction if it did not borrow.
        rem_sh  = acc[2*XLEN-1:XLEN-1];
        diff    = rem_sh - {1'b0, operand};
        if (div_mode) begin
            if (diff[XLEN]) begin
                acc_nxt = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end else begin
                acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end
        end else begin
            acc_nxt = {add_sum, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mdu_controller.sv
// mdu_controller: iterative RV32M multiply/divide unit beside the EX-stage ALU.
//   CLK, RESET       clock, asynchronous active-low reset
//   START            EX holds a valid M-type instruction (level)
//   FUNC3            M-type operation select
//   OPERAND_A/B      rs1/rs2 values after forwarding
//   HOLD             pipeline frozen by memory; keep the result presented
//   FLUSH            EX instruction killed; abort to IDLE
//   STALL            combinational pipeline freeze request
//   RESULT, VALID    registered result and its qualifier
module mdu_controller
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN = MDU_XLEN
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [2:0]      FUNC3,
    input  logic [XLEN-1:0] OPERAND_A,
    input  logic [XLEN-1:0] OPERAND_B,
    input  logic            HOLD,
    input  logic            FLUSH,
    output logic            STALL,
    output logic [XLEN-1:0] RESULT,
    output logic            VALID
);

    localparam int unsigned CW   = mdu_cnt_w(XLEN);
    localparam int unsigned AW   = 2 * XLEN;
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e      state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [2:0]      func3_q, func3_d;
    logic [AW-1:0]   acc_q, acc_d, acc_nxt;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic            neg_q, neg_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            valid_q, valid_d;

    logic            sgn_a, sgn_b, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b, fast_res, fix_res, div_val;
    logic [AW-1:0]   prod;

    mdu_iter_core #(.XLEN(XLEN)) u_core (
        .acc      (acc_q),
        .operand  (opnd_q),
        .div_mode (func3_q[2]),
        .acc_nxt  (acc_nxt)
    );

    // Operand decode: sign handling, magnitudes and one-cycle special cases.
    always_comb begin
        sgn_a    = (FUNC3 != F3_MULHU) && (FUNC3 != F3_DIVU) && (FUNC3 != F3_REMU);
        sgn_b    = sgn_a && (FUNC3 != F3_MULHSU);
        a_neg    = sgn_a && OPERAND_A[XLEN-1];
        b_neg    = sgn_b && OPERAND_B[XLEN-1];
        mag_a    = a_neg ? -OPERAND_A : OPERAND_A;
        mag_b    = b_neg ? -OPERAND_B : OPERAND_B;
        div_zero = FUNC3[2] && (OPERAND_B == '0);
        div_ovf  = ((FUNC3 == F3_DIV) || (FUNC3 == F3_REM)) &&
                   (OPERAND_A == SMIN) && (OPERAND_B == '1);
        if (div_zero) begin
            fast_res = FUNC3[1] ? OPERAND_A : '1;
        end else begin
            fast_res = FUNC3[1] ? '0 : SMIN;
        end
    end

    // Sign fixup of the final iteration's accumulator.
    always_comb begin
        prod    = neg_q ? -acc_nxt : acc_nxt;
        div_val = func3_q[1] ? acc_nxt[AW-1:XLEN] : acc_nxt[XLEN-1:0];
        if (func3_q[2]) begin
            fix_res = neg_q ? -div_val : div_val;
        end else if (func3_q == F3_MUL) begin
            fix_res = prod[XLEN-1:0];
        end else begin
            fix_res = prod[AW-1:XLEN];
        end
    end

    // Next-state and register-input logic.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        func3_d  = func3_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        result_d = result_q;
        valid_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START && !FLUSH) begin
                    // Multiply is commutative, so both ops load A in lo and B as operand.
                    func3_d = FUNC3;
                    acc_d   = {{XLEN{1'b0}}, mag_a};
                    opnd_d  = mag_b;
                    neg_d   = (FUNC3[2:1] == 2'b11) ? a_neg : (a_neg ^ b_neg);
                    count_d = '0;
                    if (div_zero || div_ovf) begin
                        state_d  = ST_DONE;
                        result_d = fast_res;
                        valid_d  = 1'b1;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                acc_d   = acc_nxt;
                count_d = CW'(count_q + 1'b1);
                if (count_q == CW'(XLEN - 1)) begin
                    state_d  = ST_DONE;
                    result_d = fix_res;
                    valid_d  = 1'b1;
                end
            end
            ST_DONE: begin
                if (HOLD) begin
                    valid_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A killed instruction never produces a result.
        if (FLUSH) begin
            state_d  = ST_IDLE;
            valid_d  = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            func3_q  <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            func3_q  <= func3_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign STALL  = RESET & START & (state_q != ST_DONE) & ~FLUSH;
    assign RESULT = result_q;
    assign VALID  = valid_q;

endmodule
